// File: rtl/kernel_stream_sink_if.sv
// ---------------------------------------------------------------------------
// kernel_stream_sink_if
// Purpose : valid/ready stream carrying one data word per transfer from a
//           kernel output port to its consumer.
// Signals : s_data  - data word, driven by the kernel
//           s_valid - kernel has a word on s_data (kernel ovalid)
//           s_ready - consumer can take the word (kernel oready)
// Modports: master - kernel side (drives data/valid, observes ready)
//           slave  - consumer side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface kernel_stream_sink_if #(
    parameter int STREAMW = 32
);
    logic [STREAMW-1:0] s_data;
    logic               s_valid;
    logic               s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/kernel_stream_sink.sv
// ---------------------------------------------------------------------------
// kernel_stream_sink
// Purpose : consumer end of a kernel output stream. Collects nwords results,
//           buffers them in a small skid FIFO and writes them to sequential
//           addresses of a memory write port that may stall.
// Ports   : clk       - clock
//           rst       - synchronous reset, active-high
//           start     - begin a transfer (only honoured in IDLE)
//           nwords    - number of words to collect, latched on start
//           s_stream  - stream slave port (s_data, s_valid, s_ready)
//           wr_en     - memory write strobe (output register holds a word)
//           wr_addr   - memory write address
//           wr_data   - memory write data
//           wr_stall  - memory not accepting; wr_* held stable while high
//           busy      - transfer in progress (RUN or DRAIN)
//           done      - one-cycle pulse at the end of a transfer
//           checksum  - running sum of accepted words
// Options : KSINK_CHECKSUM_EN - when defined, checksum accumulates every
//           accepted word (mod 2^STREAMW) and clears on start; otherwise
//           checksum is tied to zero.
// ---------------------------------------------------------------------------
module kernel_stream_sink #(
    parameter int STREAMW    = 32,
    parameter int ADDRW      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDRW-1:0]     nwords,
    kernel_stream_sink_if.slave  s_stream,
    output logic                 wr_en,
    output logic [ADDRW-1:0]     wr_addr,
    output logic [STREAMW-1:0]   wr_data,
    input  logic                 wr_stall,
    output logic                 busy,
    output logic                 done,
    output logic [STREAMW-1:0]   checksum
);

    localparam int               PTRW = $clog2(FIFO_DEPTH);
    localparam logic [ADDRW-1:0] BASE = ADDRW'(BASE_ADDR);
    localparam logic [PTRW:0]    FULL_COUNT = (PTRW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ADDRW-1:0]   nwords_q;
    logic [ADDRW-1:0]   accepted;

    logic [STREAMW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTRW-1:0]    rd_ptr;
    logic [PTRW-1:0]    wr_ptr;
    logic [PTRW:0]      fifo_count;

    logic               fifo_full;
    logic               fifo_empty;
    logic               start_ok;
    logic               push;
    logic               pop;
    logic               load_out;
    logic               write_done;

    // Handshake and datapath qualifiers. s_ready is built only from
    // registered state so the kernel never sees a valid->ready loop; the
    // FIFO deasserts ready on full even if a pop is happening that cycle.
    // The output register refills whenever it is empty or its word is
    // leaving this cycle, which gives one word per cycle when not stalled.
    assign fifo_full         = (fifo_count == FULL_COUNT);
    assign fifo_empty        = (fifo_count == '0);
    assign start_ok          = (state == IDLE) && start;
    assign s_stream.s_ready  = (state == RUN) && !fifo_full && (accepted < nwords_q);
    assign push              = s_stream.s_valid && s_stream.s_ready;
    assign write_done        = wr_en && !wr_stall;
    assign load_out          = !wr_en || !wr_stall;
    assign pop               = load_out && !fifo_empty;
    assign busy              = (state == RUN) || (state == DRAIN);
    assign done              = (state == DONE);

    // State register for the transfer sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length request goes straight to DONE so the
    // requester still gets its completion pulse. DRAIN waits until both the
    // FIFO and the output register have emptied into memory.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (nwords == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accepted == nwords_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !wr_en) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request length and accepted-word counter; both restart on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            nwords_q <= '0;
            accepted <= '0;
        end else if (start_ok) begin
            nwords_q <= nwords;
            accepted <= '0;
        end else if (push) begin
            accepted <= accepted + ADDRW'(1);
        end
    end

    // Skid FIFO pointers and occupancy. Depth is a power of two so the
    // pointers wrap on their own; reset flushes any partial transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTRW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTRW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage. Contents need no reset because occupancy is tracked
    // separately and only valid entries are ever read out.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= s_stream.s_data;
        end
    end

    // Memory-side output register. wr_en marks it as holding a word; the
    // word and address stay put while wr_stall is high. The address steps
    // after each completed write and wraps naturally at 2^ADDRW.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= BASE;
            wr_data <= '0;
        end else begin
            if (start_ok) begin
                wr_addr <= BASE;
            end else if (write_done) begin
                wr_addr <= wr_addr + ADDRW'(1);
            end

            if (pop) begin
                wr_en   <= 1'b1;
                wr_data <= fifo_mem[rd_ptr];
            end else if (write_done) begin
                wr_en   <= 1'b0;
            end
        end
    end

`ifdef KSINK_CHECKSUM_EN
    logic [STREAMW-1:0] checksum_q;

    // Running sum of accepted words. Nothing is accepted outside RUN, so
    // the value holds from the DONE cycle until the next start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (push) begin
            checksum_q <= checksum_q + s_stream.s_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_kernel_stream_sink.sv
// ---------------------------------------------------------------------------
// tb_kernel_stream_sink
// Purpose : self-checking bench for kernel_stream_sink. A table of transfer
//           records (length, data, valid pattern, stall length) drives the
//           main instance; every accepted word is pushed to a scoreboard with
//           its expected address and popped when the memory port writes it.
//           Hand-written sequences cover zero-length requests, reset in the
//           middle of a transfer and address wrap on a narrow instance.
// ---------------------------------------------------------------------------
module tb_kernel_stream_sink;

    localparam int STREAMW    = 32;
    localparam int ADDRW      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int NVEC       = 6;

`ifdef KSINK_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        int          nwords;
        logic [31:0] first;
        bit          toggle;
        int          stall_len;
        int          exp_writes;
        logic [31:0] exp_sum;
        int          exp_block;
        int          exp_span;
    } vec_t;

    typedef struct {
        logic [ADDRW-1:0]   addr;
        logic [STREAMW-1:0] data;
    } sb_t;

    logic clk = 1'b0;

    // Free-running 100 MHz clock shared by both instances.
    always #5 clk = ~clk;

    logic               rst;
    logic               start;
    logic [ADDRW-1:0]   nwords;
    logic               wr_en;
    logic [ADDRW-1:0]   wr_addr;
    logic [STREAMW-1:0] wr_data;
    logic               wr_stall;
    logic               busy;
    logic               done;
    logic [STREAMW-1:0] checksum;

    logic               start_w;
    logic [3:0]         nwords_w;
    logic               wr_en_w;
    logic [3:0]         wr_addr_w;
    logic [STREAMW-1:0] wr_data_w;
    logic               wr_stall_w;
    logic               busy_w;
    logic               done_w;
    logic [STREAMW-1:0] checksum_w;

    kernel_stream_sink_if #(.STREAMW(STREAMW)) s_if ();
    kernel_stream_sink_if #(.STREAMW(STREAMW)) s_w ();

    kernel_stream_sink #(
        .STREAMW    (STREAMW),
        .ADDRW      (ADDRW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .nwords   (nwords),
        .s_stream (s_if),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_stall (wr_stall),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    kernel_stream_sink #(
        .STREAMW    (STREAMW),
        .ADDRW      (4),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (14)
    ) dut_wrap (
        .clk      (clk),
        .rst      (rst),
        .start    (start_w),
        .nwords   (nwords_w),
        .s_stream (s_w),
        .wr_en    (wr_en_w),
        .wr_addr  (wr_addr_w),
        .wr_data  (wr_data_w),
        .wr_stall (wr_stall_w),
        .busy     (busy_w),
        .done     (done_w),
        .checksum (checksum_w)
    );

    int          checks = 0;
    int          errors = 0;
    sb_t         sb[$];
    vec_t        vecs[NVEC];
    int          done_count = 0;
    int          write_count = 0;
    int          sample_cycle = 0;
    int          first_write_cyc = 0;
    int          last_write_cyc = 0;
    logic [31:0] done_csum = '0;
    int          sent = 0;
    int          stall_cnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at the falling edge: records done pulses and checks every
    // write that will complete on the coming rising edge against the
    // scoreboard head.
    task automatic sampleCycle();
        sb_t e;
        sample_cycle++;
        if (done) begin
            done_count++;
            done_csum = checksum;
        end
        if (!rst && wr_en && !wr_stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
                checkOutput("wr_data", 64'(wr_data), 64'(e.data));
            end
            if (write_count == 0) begin
                first_write_cyc = sample_cycle;
            end
            last_write_cyc = sample_cycle;
            write_count++;
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        sampleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic updateStall(input int stall_len);
        wr_stall = (stall_len != 0) && (sent != 0) && (stall_cnt < stall_len);
        if (wr_stall) begin
            stall_cnt++;
        end
    endtask

    // Runs one complete transfer described by a table record and checks
    // ordering, counts, the done pulse and the checksum.
    task automatic applyStimulus(input vec_t v);
        int cyc;
        int block_at;
        nextCycle();
        start           = 1'b1;
        nwords          = ADDRW'(v.nwords);
        s_if.s_valid    = 1'b0;
        wr_stall        = 1'b0;
        sent            = 0;
        stall_cnt       = 0;
        done_count      = 0;
        write_count     = 0;
        first_write_cyc = 0;
        last_write_cyc  = 0;
        block_at        = 0;
        cyc             = 0;
        while (sent < v.nwords && cyc < 500) begin
            nextCycle();
            start = 1'b0;
            updateStall(v.stall_len);
            if (wr_stall && !s_if.s_ready && block_at == 0) begin
                block_at = sent;
            end
            s_if.s_valid = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            s_if.s_data  = v.first + 32'(sent);
            if (s_if.s_valid && s_if.s_ready) begin
                sb.push_back('{ADDRW'(sent), v.first + 32'(sent)});
                sent++;
            end
            cyc++;
        end

        nextCycle();
        start = 1'b0;
        updateStall(v.stall_len);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'hDEAD_BEEF;
        checkOutput("ready_after_last", 64'(s_if.s_ready), 64'd0);
        while (done_count == 0 && cyc < 500) begin
            nextCycle();
            updateStall(v.stall_len);
            cyc++;
        end
        s_if.s_valid = 1'b0;
        wr_stall     = 1'b0;
        checkOutput("done_reached", 64'(done_count != 0), 64'd1);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("checksum_done", 64'(done_csum), CSUM_EN ? 64'(v.exp_sum) : 64'd0);

        repeat (3) nextCycle();
        checkOutput("done_pulses", 64'(done_count), 64'd1);
        checkOutput("write_count", 64'(write_count), 64'(v.exp_writes));
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        checkOutput("checksum_hold", 64'(checksum), CSUM_EN ? 64'(v.exp_sum) : 64'd0);
        checkOutput("words_sent", 64'(sent), 64'(v.nwords));
        if (v.exp_block != 0) begin
            checkOutput("ready_block_words", 64'(block_at), 64'(v.exp_block));
        end
        if (v.exp_span >= 0) begin
            checkOutput("write_span", 64'(last_write_cyc - first_write_cyc), 64'(v.exp_span));
        end
        sb.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, 64'(s_if.s_ready), 64'd0);
        checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        checkOutput({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        checkOutput({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Main test sequence.
    initial begin
        int          cyc;
        int          n;
        int          d;
        int          first_c;
        int          last_c;
        logic [3:0]  exp_wrap [4];
        vec_t        fresh;

        exp_wrap = '{4'd14, 4'd15, 4'd0, 4'd1};

        vecs[0] = '{4, 32'd1, 1'b0, 0, 4, 32'd10, 0, 3};
        vecs[1] = '{8, 32'd16, 1'b0, 10, 8, 32'd156, FIFO_DEPTH + 1, -1};
        vecs[2] = '{0, 32'd5, 1'b0, 0, 0, 32'd0, 0, -1};
        vecs[3] = '{3, 32'd100, 1'b1, 0, 3, 32'd303, 0, 4};
        vecs[4] = '{5, 32'hFFFF_FFFE, 1'b0, 3, 5, 32'd0, 0, -1};
        vecs[5] = '{1, 32'd7, 1'b0, 0, 1, 32'd7, 0, 0};

        rst          = 1'b1;
        start        = 1'b0;
        nwords       = '0;
        wr_stall     = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        start_w      = 1'b0;
        nwords_w     = '0;
        wr_stall_w   = 1'b0;
        s_w.s_valid  = 1'b0;
        s_w.s_data   = '0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("reset");
        checkOutput("reset_wrap_addr", 64'(wr_addr_w), 64'd14);

        $display("[TB] table-driven transfers");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] zero-length request");
        nextCycle();
        start  = 1'b1;
        nwords = '0;
        nextCycle();
        start = 1'b0;
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_wr_en", 64'(wr_en), 64'd0);
        nextCycle();
        checkOutput("zero_done_clear", 64'(done), 64'd0);

        $display("[TB] reset in the middle of a transfer");
        nextCycle();
        start       = 1'b1;
        nwords      = ADDRW'(6);
        sent        = 0;
        done_count  = 0;
        write_count = 0;
        cyc         = 0;
        while (sent < 2 && cyc < 50) begin
            nextCycle();
            start        = 1'b0;
            s_if.s_valid = 1'b1;
            s_if.s_data  = 32'h200 + 32'(sent);
            if (s_if.s_ready) begin
                sb.push_back('{ADDRW'(sent), 32'h200 + 32'(sent)});
                sent++;
            end
            cyc++;
        end
        nextCycle();
        s_if.s_valid = 1'b0;
        rst          = 1'b1;
        nextCycle();
        rst = 1'b0;
        sb.delete();
        checkResetValues("midrst");
        checkOutput("midrst_writes", 64'(write_count), 64'd0);
        repeat (2) nextCycle();
        checkOutput("midrst_no_done", 64'(done_count), 64'd0);
        fresh = '{2, 32'hA0, 1'b0, 0, 2, 32'h141, 0, 1};
        applyStimulus(fresh);

        $display("[TB] address wrap on narrow instance");
        nextCycle();
        start_w  = 1'b1;
        nwords_w = 4'd4;
        n        = 0;
        d        = 0;
        cyc      = 0;
        first_c  = 0;
        last_c   = 0;
        while (n < 4 && cyc < 50) begin
            nextCycle();
            start_w     = 1'b0;
            s_w.s_valid = (d < 4);
            s_w.s_data  = 32'h50 + 32'(d);
            if (s_w.s_valid && s_w.s_ready) begin
                d++;
            end
            if (wr_en_w) begin
                checkOutput("wrap_addr", 64'(wr_addr_w), 64'(exp_wrap[n]));
                checkOutput("wrap_data", 64'(wr_data_w), 64'(32'h50 + 32'(n)));
                if (n == 0) begin
                    first_c = cyc;
                end
                last_c = cyc;
                n++;
            end
            cyc++;
        end
        s_w.s_valid = 1'b0;
        checkOutput("wrap_count", 64'(n), 64'd4);
        checkOutput("wrap_span", 64'(last_c - first_c), 64'd3);
        repeat (5) nextCycle();
        checkOutput("wrap_idle", 64'(busy_w), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
